// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing one FIFO write port between
//               NUM_REQ requesters. Grant, write enable and write data are
//               combinational from registered state, req and fifo_full, so a
//               word is written in the same cycle it is requested.
//               Optional burst tenures (up to MAX_BURST words per grant) are
//               compiled in when the macro FIFO_ARB_BURST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data,
  output logic                      busy
);

  localparam int                 c_idx_w    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_idx_w-1:0] c_last_rst = c_idx_w'(NUM_REQ - 1);

  // Elaboration-time guard on the legal parameter ranges.
  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || MAX_BURST < 1 || MAX_BURST > 16) begin : g_param_check
    $error("fifo_wr_arbiter: parameter out of legal range");
  end

  // Index of the most recently granted requester; search starts one past it.
  logic [c_idx_w-1:0] r_last;

  // Round-robin candidate, valid only when some requester is asking.
  logic               w_rr_found;
  logic [c_idx_w-1:0] w_rr_idx;

  // Final grant decision shared by gnt, fifo_wr_en and fifo_data.
  logic               w_gnt_vld;
  logic [c_idx_w-1:0] w_gnt_idx;

`ifdef FIFO_ARB_BURST_EN
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [4:0] c_max_burst = 5'(MAX_BURST);
  localparam bit         c_burst_on  = (MAX_BURST > 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_idx_w-1:0] r_owner;
  logic [c_idx_w-1:0] w_owner_nxt;
  logic [4:0]         r_burst_cnt;
  logic [4:0]         w_burst_cnt_nxt;
`endif

  // Search requesters starting at (last+1) mod NUM_REQ; first hit wins.
  always_comb begin
    logic [c_idx_w-1:0] cand;
    cand       = '0;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = c_idx_w'((int'(r_last) + i) % NUM_REQ);
      if (!w_rr_found && req[cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = cand;
      end
    end
  end

  // Pick the granted requester; nothing is granted in reset or while full.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = w_rr_idx;
`ifdef FIFO_ARB_BURST_EN
    if (r_state == ST_BURST) begin
      // An open tenure locks out everybody except its owner.
      w_gnt_idx = r_owner;
      w_gnt_vld = req[r_owner] & ~fifo_full & reset;
    end else begin
      w_gnt_vld = w_rr_found & ~fifo_full & reset;
    end
`else
    w_gnt_vld = w_rr_found & ~fifo_full & reset;
`endif
  end

  // Drive the FIFO write port from the grant decision.
  always_comb begin
    gnt       = '0;
    fifo_data = '0;
    if (w_gnt_vld) begin
      gnt[w_gnt_idx] = 1'b1;
      fifo_data      = req_data[w_gnt_idx*DATA_W +: DATA_W];
    end
    fifo_wr_en = |gnt;
  end

  // Round-robin pointer moves on every accepted word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= c_last_rst;
    end else if (w_gnt_vld) begin
      r_last <= w_gnt_idx;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  // Tenure state register; reset aborts any open burst.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_burst_cnt <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Tenure open/close decisions and burst word counting.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld && c_burst_on) begin
          // The word accepted here is the first of the tenure.
          w_state_nxt     = ST_BURST;
          w_owner_nxt     = w_gnt_idx;
          w_burst_cnt_nxt = 5'd1;
        end
      end
      ST_BURST: begin
        if (fifo_full) begin
          // Paused: hold owner, count and state until space returns.
          w_state_nxt = ST_BURST;
        end else if (!req[r_owner]) begin
          w_state_nxt     = ST_IDLE;
          w_burst_cnt_nxt = 5'd0;
        end else if (w_gnt_vld) begin
          if (r_burst_cnt + 5'd1 == c_max_burst) begin
            w_state_nxt     = ST_IDLE;
            w_burst_cnt_nxt = 5'd0;
          end else begin
            w_burst_cnt_nxt = r_burst_cnt + 5'd1;
          end
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_burst_cnt_nxt = 5'd0;
      end
    endcase
  end

  assign busy = (r_state == ST_BURST);
`else
  assign busy = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Scoreboard bench for fifo_wr_arbiter. Directed cycles push
//               the hand-computed expected write into a queue; a monitor pops
//               and compares on every FIFO write. Adapts its expectations to
//               the FIFO_ARB_BURST_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

`ifdef FIFO_ARB_BURST_EN
  localparam int BURST = 1;
`else
  localparam int BURST = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  gnt;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data;
  logic        busy;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mq[$];
  bit         cap = 1'b0;
  int         wcnt[4];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every write against the scoreboard head.
  always @(negedge clk) begin
    check("onehot_gnt", {31'd0, $onehot0(gnt)}, 32'd1);
    check("wr_en_is_or_gnt", {31'd0, fifo_wr_en}, {31'd0, |gnt});
    if (fifo_full) check("write_while_full", {31'd0, fifo_wr_en}, 32'd0);
    if (fifo_wr_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got gnt=%b data=%0h expected no write at %0t", gnt, fifo_data, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("gnt", {28'd0, gnt}, 32'(1 << e.idx));
        check("fifo_data", {24'd0, fifo_data}, {24'd0, e.data});
      end
    end
  end

  // Bench-side 16-deep FIFO capturing accepted words.
  always @(posedge clk) begin
    if (cap && reset && fifo_wr_en) mq.push_back(fifo_data);
  end

  // One clock of stimulus: drive, expect, check busy/reset outputs, confirm.
  task automatic cyc(input logic rst_n, input logic [3:0] r, input logic full,
                     input int exp_idx, input int exp_busy);
    exp_t e;
    reset     = rst_n;
    req       = r;
    fifo_full = full;
    for (int k = 0; k < 4; k++) req_data[k*8 +: 8] = {4'(k), 4'(wcnt[k])};
    if (exp_idx >= 0) begin
      e.idx  = exp_idx;
      e.data = {4'(exp_idx), 4'(wcnt[exp_idx])};
      sb.push_back(e);
    end
    @(negedge clk);
    if (exp_busy >= 0) check("busy", {31'd0, busy}, 32'(exp_busy));
    if (!rst_n) begin
      check("rst_gnt", {28'd0, gnt}, 32'd0);
      check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
      check("rst_data", {24'd0, fifo_data}, 32'd0);
    end
    @(posedge clk);
    #1;
    check("missed_grant", 32'(sb.size()), 32'd0);
    if (sb.size() != 0) sb.delete();
    if (exp_idx >= 0) wcnt[exp_idx]++;
  endtask

  task automatic do_reset();
    cap = 1'b0;
    mq.delete();
    for (int k = 0; k < 4; k++) wcnt[k] = 0;
    cyc(1'b0, 4'b1111, 1'b0, -1, -1);
    cyc(1'b0, 4'b1111, 1'b0, -1, 0);
  endtask

  initial begin
    logic [3:0] pat[4];
    int         exp[4];
    int         rb[4];
    logic [7:0] d;

    @(posedge clk);
    #1;

    // Reset with all requesting, then round-robin from requester 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (BURST != 0) cyc(1'b1, 4'b1111, 1'b0, i / 4, (i % 4 != 0) ? 1 : 0);
      else            cyc(1'b1, 4'b1111, 1'b0, i % 4, 0);
    end

`ifdef FIFO_ARB_BURST_EN
    // Burst paused by full after the second word.
    do_reset();
    cyc(1'b1, 4'b0100, 1'b0, 2, 0);
    cyc(1'b1, 4'b0100, 1'b0, 2, 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0100, 1'b1, -1, 1);
    cyc(1'b1, 4'b0100, 1'b0, 2, 1);
    cyc(1'b1, 4'b0100, 1'b0, 2, 1);
    cyc(1'b1, 4'b0000, 1'b0, -1, 0);

    // Owner drops req mid-burst; next grant goes to requester 2.
    do_reset();
    cyc(1'b1, 4'b0110, 1'b0, 1, 0);
    cyc(1'b1, 4'b0110, 1'b0, 1, 1);
    cyc(1'b1, 4'b0100, 1'b0, -1, 1);
    cyc(1'b1, 4'b0100, 1'b0, 2, 0);
    cyc(1'b1, 4'b0000, 1'b0, -1, 1);
    cyc(1'b1, 4'b0000, 1'b0, -1, 0);
`else
    // Skipping of idle slots (last = 3 here).
    cyc(1'b1, 4'b1010, 1'b0, 1, 0);
    cyc(1'b1, 4'b1010, 1'b0, 3, 0);
    cyc(1'b1, 4'b1010, 1'b0, 1, 0);
    // Full blocks grants, then arbitration resumes from last+1.
    cyc(1'b1, 4'b1111, 1'b1, -1, 0);
    cyc(1'b1, 4'b1111, 1'b1, -1, 0);
    cyc(1'b1, 4'b1111, 1'b0, 2, 0);
    cyc(1'b1, 4'b0000, 1'b0, -1, 0);
    cyc(1'b1, 4'b1001, 1'b0, 3, 0);
    cyc(1'b1, 4'b1001, 1'b0, 0, 0);
`endif

    // Reset in the middle of a tenure; arbitration restarts cleanly.
    do_reset();
    cyc(1'b1, 4'b0100, 1'b0, 2, 0);
    cyc(1'b1, 4'b0100, 1'b0, 2, BURST);
    cyc(1'b0, 4'b1111, 1'b0, -1, -1);
    cyc(1'b0, 4'b1111, 1'b0, -1, 0);
    cyc(1'b1, 4'b0110, 1'b0, 1, 0);
    cyc(1'b1, 4'b0110, 1'b0, (BURST != 0) ? 1 : 2, BURST);
    cyc(1'b1, 4'b0000, 1'b0, -1, BURST);
    cyc(1'b1, 4'b0000, 1'b0, -1, 0);

    // Fill a 16-deep FIFO, then confirm nothing more is written.
    do_reset();
    cap = 1'b1;
`ifdef FIFO_ARB_BURST_EN
    pat = '{4'b0011, 4'b0011, 4'b0011, 4'b0011};
`else
    pat = '{4'b0001, 4'b0100, 4'b1010, 4'b0011};
    exp = '{0, 2, 3, 0};
`endif
    for (int i = 0; i < 16; i++) begin
      if (BURST != 0) cyc(1'b1, pat[i % 4], (mq.size() >= 16), (i / 4) % 2, (i % 4 != 0) ? 1 : 0);
      else            cyc(1'b1, pat[i % 4], (mq.size() >= 16), exp[i % 4], 0);
    end
    for (int i = 0; i < 2; i++) cyc(1'b1, pat[i], (mq.size() >= 16), -1, 0);
    check("fifo_level", 32'(mq.size()), 32'd16);
    for (int k = 0; k < 4; k++) rb[k] = 0;
    while (mq.size() > 0) begin
      d = mq.pop_front();
      check("readback_order", {28'd0, d[3:0]}, 32'(rb[d[5:4]]));
      rb[d[5:4]]++;
    end
    cap = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
